// File: rtl/stereo_window_fetch_if.sv
// Request, BRAM read and response signals of stereo_window_fetch.
// slave is the fetch unit's view; master is the matcher/BRAM environment's view.
interface stereo_window_fetch_if #(
   parameter int unsigned IMG_WIDTH  = 320,
   parameter int unsigned IMG_HEIGHT = 40,
   parameter int unsigned PIXEL_BITS = 8,
   parameter int unsigned WIN_PIXELS = 6
);
   localparam int unsigned HW = $clog2(IMG_WIDTH) + 1;
   localparam int unsigned VW = $clog2(IMG_HEIGHT) + 1;
   localparam int unsigned AW = $clog2(IMG_WIDTH * IMG_HEIGHT);
   localparam int unsigned WW = PIXEL_BITS * WIN_PIXELS;

   logic                  req_valid;
   logic                  req_ready;
   logic [HW-1:0]         left_hcount;
   logic [VW-1:0]         left_vcount;
   logic [HW-1:0]         right_hcount;
   logic [VW-1:0]         right_vcount;
   logic [AW-1:0]         left_addr;
   logic [AW-1:0]         right_addr;
   logic [PIXEL_BITS-1:0] left_rdata;
   logic [PIXEL_BITS-1:0] right_rdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [WW-1:0]         left_win;
   logic [WW-1:0]         right_win;
   logic                  coord_err;

   modport slave (
      input  req_valid, left_hcount, left_vcount, right_hcount, right_vcount,
      input  left_rdata, right_rdata, resp_ready,
      output req_ready, left_addr, right_addr, resp_valid, left_win, right_win, coord_err
   );

   modport master (
      output req_valid, left_hcount, left_vcount, right_hcount, right_vcount,
      output left_rdata, right_rdata, resp_ready,
      input  req_ready, left_addr, right_addr, resp_valid, left_win, right_win, coord_err
   );
endinterface

// File: rtl/stereo_window_fetch.sv
// Fetches WIN_PIXELS consecutive pixels from the left/right frame BRAMs and returns packed windows.
// Build option: define ZERO_PAD_EN to zero window pixels past the right image edge instead of clamping.
module stereo_window_fetch #(
   parameter int unsigned IMG_WIDTH    = 320,
   parameter int unsigned IMG_HEIGHT   = 40,
   parameter int unsigned PIXEL_BITS   = 8,
   parameter int unsigned WIN_PIXELS   = 6,
   parameter int unsigned BRAM_LATENCY = 2
) (
   input  logic                  clk_100mhz,
   input  logic                  sys_rst_n,
   stereo_window_fetch_if.slave  bus
);
   localparam int unsigned HW = $clog2(IMG_WIDTH) + 1;
   localparam int unsigned VW = $clog2(IMG_HEIGHT) + 1;
   localparam int unsigned AW = $clog2(IMG_WIDTH * IMG_HEIGHT);
   localparam int unsigned CW = HW + 1;
   localparam int unsigned KW = (WIN_PIXELS > 1) ? $clog2(WIN_PIXELS) : 1;
   localparam int unsigned PL = BRAM_LATENCY;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

   state_t        state;
   logic [HW-1:0] lh, rh;
   logic [VW-1:0] lv, rv;
   logic          l_ok, r_ok;
   logic [KW-1:0] k;

   // Issue tag travels alongside the registered address, then through the latency pipe.
   logic          tag_v, tag_le, tag_re;
   logic [KW-1:0] tag_k;
   logic [PL-1:0] pipe_v, pipe_le, pipe_re;
   logic [KW-1:0] pipe_k [PL];

   logic          l_ok_c, r_ok_c;
   logic [CW-1:0] lcol_raw_c, rcol_raw_c, lcol_c, rcol_c;
   logic          l_in_c, r_in_c, l_en_c, r_en_c;
   logic [AW-1:0] laddr_c, raddr_c;
   logic          last_out_c;

   always_comb begin
      l_ok_c     = (bus.left_hcount  < HW'(IMG_WIDTH)) && (bus.left_vcount  < VW'(IMG_HEIGHT));
      r_ok_c     = (bus.right_hcount < HW'(IMG_WIDTH)) && (bus.right_vcount < VW'(IMG_HEIGHT));
      lcol_raw_c = CW'(lh) + CW'(k);
      rcol_raw_c = CW'(rh) + CW'(k);
      l_in_c     = lcol_raw_c < CW'(IMG_WIDTH);
      r_in_c     = rcol_raw_c < CW'(IMG_WIDTH);
      lcol_c     = l_in_c ? lcol_raw_c : CW'(IMG_WIDTH - 1);
      rcol_c     = r_in_c ? rcol_raw_c : CW'(IMG_WIDTH - 1);
      laddr_c    = AW'(32'(lv) * IMG_WIDTH + 32'(lcol_c));
      raddr_c    = AW'(32'(rv) * IMG_WIDTH + 32'(rcol_c));
`ifdef ZERO_PAD_EN
      l_en_c     = l_ok && l_in_c;
      r_en_c     = r_ok && r_in_c;
`else
      l_en_c     = l_ok;
      r_en_c     = r_ok;
`endif
      last_out_c = pipe_v[PL-1] && (pipe_k[PL-1] == KW'(WIN_PIXELS - 1));
   end

   always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state          <= IDLE;
         lh             <= '0;
         rh             <= '0;
         lv             <= '0;
         rv             <= '0;
         l_ok           <= 1'b0;
         r_ok           <= 1'b0;
         k              <= '0;
         tag_v          <= 1'b0;
         tag_le         <= 1'b0;
         tag_re         <= 1'b0;
         tag_k          <= '0;
         pipe_v         <= '0;
         pipe_le        <= '0;
         pipe_re        <= '0;
         for (int i = 0; i < int'(PL); i++) pipe_k[i] <= '0;
         bus.req_ready  <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.left_win   <= '0;
         bus.right_win  <= '0;
         bus.coord_err  <= 1'b0;
         bus.left_addr  <= '0;
         bus.right_addr <= '0;
      end else begin
         tag_v  <= 1'b0;
         tag_le <= 1'b0;
         tag_re <= 1'b0;
         for (int i = int'(PL) - 1; i > 0; i--) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_le[i] <= pipe_le[i-1];
            pipe_re[i] <= pipe_re[i-1];
            pipe_k[i]  <= pipe_k[i-1];
         end
         pipe_v[0]  <= tag_v;
         pipe_le[0] <= tag_le;
         pipe_re[0] <= tag_re;
         pipe_k[0]  <= tag_k;

         // Emerging read data lands in its slot; pixel 0 is the most significant.
         for (int s = 0; s < int'(WIN_PIXELS); s++) begin
            if (pipe_v[PL-1] && (pipe_k[PL-1] == KW'(s))) begin
               if (pipe_le[PL-1])
                  bus.left_win[PIXEL_BITS*(WIN_PIXELS-s)-1 -: PIXEL_BITS] <= bus.left_rdata;
               if (pipe_re[PL-1])
                  bus.right_win[PIXEL_BITS*(WIN_PIXELS-s)-1 -: PIXEL_BITS] <= bus.right_rdata;
            end
         end

         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lh             <= bus.left_hcount;
                  lv             <= bus.left_vcount;
                  rh             <= bus.right_hcount;
                  rv             <= bus.right_vcount;
                  l_ok           <= l_ok_c;
                  r_ok           <= r_ok_c;
                  k              <= '0;
                  bus.coord_err  <= !(l_ok_c && r_ok_c);
                  bus.left_win   <= '0;
                  bus.right_win  <= '0;
                  bus.req_ready  <= 1'b0;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               tag_v  <= 1'b1;
               tag_k  <= k;
               tag_le <= l_en_c;
               tag_re <= r_en_c;
               if (l_en_c) bus.left_addr  <= laddr_c;
               if (r_en_c) bus.right_addr <= raddr_c;
               if (k == KW'(WIN_PIXELS - 1)) state <= DRAIN;
               else                          k     <= k + KW'(1);
            end
            DRAIN: begin
               if (last_out_c) begin
                  bus.resp_valid <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stereo_window_fetch.sv
// Directed bench for stereo_window_fetch; BRAM model returns pixel = addr[7:0] after two cycles.
module tb_stereo_window_fetch;
   localparam int unsigned IMG_WIDTH    = 320;
   localparam int unsigned IMG_HEIGHT   = 40;
   localparam int unsigned PIXEL_BITS   = 8;
   localparam int unsigned WIN_PIXELS   = 6;
   localparam int unsigned BRAM_LATENCY = 2;
   localparam int          EXP_LAT      = 9;

   logic clk_100mhz = 1'b0;
   logic sys_rst_n  = 1'b0;
   int   checks     = 0;
   int   errors     = 0;

   stereo_window_fetch_if #(
      .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
      .PIXEL_BITS(PIXEL_BITS), .WIN_PIXELS(WIN_PIXELS)
   ) bus ();

   stereo_window_fetch #(
      .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .PIXEL_BITS(PIXEL_BITS),
      .WIN_PIXELS(WIN_PIXELS), .BRAM_LATENCY(BRAM_LATENCY)
   ) dut (
      .clk_100mhz(clk_100mhz),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   // Two-cycle synchronous BRAM model
   logic [7:0] ld0 = 8'h00, ld1 = 8'h00, rd0 = 8'h00, rd1 = 8'h00;
   always @(posedge clk_100mhz) begin
      ld0 <= bus.left_addr[7:0];
      ld1 <= ld0;
      rd0 <= bus.right_addr[7:0];
      rd1 <= rd0;
   end
   assign bus.left_rdata  = ld1;
   assign bus.right_rdata = rd1;

   task automatic send_req(input int lh, input int lv, input int rh, input int rv, output int lat);
      lat = 0;
      @(negedge clk_100mhz);
      bus.req_valid    = 1'b1;
      bus.left_hcount  = 10'(lh);
      bus.left_vcount  = 7'(lv);
      bus.right_hcount = 10'(rh);
      bus.right_vcount = 7'(rv);
      @(posedge clk_100mhz);
      #1;
      bus.req_valid    = 1'b0;
      bus.left_hcount  = 10'd77;
      bus.left_vcount  = 7'd5;
      bus.right_hcount = 10'd200;
      bus.right_vcount = 7'd30;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_100mhz);
         #1;
         if (bus.resp_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic accept_resp();
      @(negedge clk_100mhz);
      bus.resp_ready = 1'b1;
      @(posedge clk_100mhz);
      #1;
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_100mhz);
      @(negedge clk_100mhz);
      sys_rst_n = 1'b1;
      @(posedge clk_100mhz);
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
      checks++; if (bus.left_win !== 48'h0) begin errors++; $display("FAIL reset_left_win got %h exp 0", bus.left_win); end
      checks++; if (bus.right_win !== 48'h0) begin errors++; $display("FAIL reset_right_win got %h exp 0", bus.right_win); end
      checks++; if (bus.coord_err !== 1'b0) begin errors++; $display("FAIL reset_coord_err got %b exp 0", bus.coord_err); end
      checks++; if (bus.left_addr !== 14'h0 || bus.right_addr !== 14'h0) begin
         errors++; $display("FAIL reset_addr got %h/%h exp 0/0", bus.left_addr, bus.right_addr);
      end
   endtask

   task automatic test_basic();
      int lat;
      send_req(1, 2, 1, 2, lat);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, EXP_LAT); end
      checks++; if (bus.left_win !== 48'h818283848586) begin errors++; $display("FAIL basic_left_win got %h exp 818283848586", bus.left_win); end
      checks++; if (bus.right_win !== 48'h818283848586) begin errors++; $display("FAIL basic_right_win got %h exp 818283848586", bus.right_win); end
      checks++; if (bus.coord_err !== 1'b0) begin errors++; $display("FAIL basic_coord_err got %b exp 0", bus.coord_err); end
      accept_resp();
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL basic_after_accept got valid %b ready %b exp 0 1", bus.resp_valid, bus.req_ready);
      end
   endtask

   task automatic test_independent();
      int lat;
      send_req(0, 10, 10, 10, lat);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL indep_latency got %0d exp %0d", lat, EXP_LAT); end
      checks++; if (bus.left_win !== 48'h808182838485) begin errors++; $display("FAIL indep_left_win got %h exp 808182838485", bus.left_win); end
      checks++; if (bus.right_win !== 48'h8a8b8c8d8e8f) begin errors++; $display("FAIL indep_right_win got %h exp 8a8b8c8d8e8f", bus.right_win); end
      accept_resp();
   endtask

   task automatic test_right_edge();
      int lat;
      logic [47:0] exp_l, exp_r;
`ifdef ZERO_PAD_EN
      exp_l = 48'hFDFEFF000000;
      exp_r = 48'hFF0000000000;
`else
      exp_l = 48'hFDFEFFFFFFFF;
      exp_r = 48'hFFFFFFFFFFFF;
`endif
      send_req(317, 39, 319, 39, lat);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL edge_latency got %0d exp %0d", lat, EXP_LAT); end
      checks++; if (bus.left_win !== exp_l) begin errors++; $display("FAIL edge_left_win got %h exp %h", bus.left_win, exp_l); end
      checks++; if (bus.right_win !== exp_r) begin errors++; $display("FAIL edge_right_win got %h exp %h", bus.right_win, exp_r); end
      checks++; if (bus.coord_err !== 1'b0) begin errors++; $display("FAIL edge_coord_err got %b exp 0", bus.coord_err); end
      accept_resp();
   endtask

   task automatic test_error();
      int lat;
      send_req(320, 0, 1, 2, lat);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL err_latency got %0d exp %0d", lat, EXP_LAT); end
      checks++; if (bus.coord_err !== 1'b1) begin errors++; $display("FAIL err_coord_err got %b exp 1", bus.coord_err); end
      checks++; if (bus.left_win !== 48'h0) begin errors++; $display("FAIL err_left_win got %h exp 0", bus.left_win); end
      checks++; if (bus.right_win !== 48'h818283848586) begin errors++; $display("FAIL err_right_win got %h exp 818283848586", bus.right_win); end
      accept_resp();
      send_req(1, 2, 1, 40, lat);
      checks++; if (bus.coord_err !== 1'b1 || bus.right_win !== 48'h0 || bus.left_win !== 48'h818283848586) begin
         errors++; $display("FAIL err_vcount got err %b L %h R %h exp 1 818283848586 0", bus.coord_err, bus.left_win, bus.right_win);
      end
      accept_resp();
   endtask

   task automatic test_back_to_back();
      int lat;
      int bad;
      send_req(0, 10, 10, 10, lat);
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, EXP_LAT); end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk_100mhz);
         #1;
         if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.left_win !== 48'h808182838485 ||
             bus.right_win !== 48'h8a8b8c8d8e8f || bus.coord_err !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
      // Response accept and next request presented together; request must wait one cycle
      @(negedge clk_100mhz);
      bus.resp_ready   = 1'b1;
      bus.req_valid    = 1'b1;
      bus.left_hcount  = 10'd1;
      bus.left_vcount  = 7'd2;
      bus.right_hcount = 10'd1;
      bus.right_vcount = 7'd2;
      @(posedge clk_100mhz);
      #1;
      bus.resp_ready = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_handover got valid %b ready %b exp 0 1", bus.resp_valid, bus.req_ready);
      end
      @(posedge clk_100mhz);
      #1;
      bus.req_valid = 1'b0;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got ready %b exp 0", bus.req_ready); end
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_100mhz);
         #1;
         if (bus.resp_valid) begin
            lat = n;
            break;
         end
      end
      checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, EXP_LAT); end
      checks++; if (bus.left_win !== 48'h818283848586 || bus.right_win !== 48'h818283848586) begin
         errors++; $display("FAIL b2b_windows got %h/%h exp 818283848586", bus.left_win, bus.right_win);
      end
      accept_resp();
   endtask

   task automatic test_reset_mid();
      int lat;
      int stale;
      @(negedge clk_100mhz);
      bus.req_valid    = 1'b1;
      bus.left_hcount  = 10'd1;
      bus.left_vcount  = 7'd2;
      bus.right_hcount = 10'd1;
      bus.right_vcount = 7'd2;
      @(posedge clk_100mhz);
      #1;
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk_100mhz);
      #2;
      sys_rst_n = 1'b0;
      #1;
      checks++; if (bus.left_addr !== 14'h0 || bus.right_addr !== 14'h0) begin
         errors++; $display("FAIL rstmid_addr got %h/%h exp 0/0", bus.left_addr, bus.right_addr);
      end
      checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_handshake got ready %b valid %b exp 1 0", bus.req_ready, bus.resp_valid);
      end
      checks++; if (bus.left_win !== 48'h0 || bus.right_win !== 48'h0 || bus.coord_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_outputs got %h/%h err %b exp 0", bus.left_win, bus.right_win, bus.coord_err);
      end
      repeat (2) @(negedge clk_100mhz);
      sys_rst_n = 1'b1;
      stale = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk_100mhz);
         #1;
         if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d bad cycles exp 0", stale); end
      send_req(10, 10, 0, 10, lat);
      checks++; if (lat !== EXP_LAT || bus.left_win !== 48'h8a8b8c8d8e8f || bus.right_win !== 48'h808182838485) begin
         errors++; $display("FAIL rstmid_recover got lat %0d L %h R %h exp 9 8a8b8c8d8e8f 808182838485", lat, bus.left_win, bus.right_win);
      end
      accept_resp();
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.resp_ready   = 1'b0;
      bus.left_hcount  = '0;
      bus.left_vcount  = '0;
      bus.right_hcount = '0;
      bus.right_vcount = '0;
      test_reset();
      test_basic();
      test_independent();
      test_right_edge();
      test_error();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
